// File: rtl/ex_pkg.sv
// Shared EX-stage definitions: unit codes, sequencer state encoding and the
// default multi-cycle latencies used by the IMul/FP units.
package ex_pkg;

    localparam logic [2:0] UNIT_NONE    = 3'd0;
    localparam logic [2:0] UNIT_IMUL    = 3'd1;
    localparam logic [2:0] UNIT_FADDSUB = 3'd2;
    localparam logic [2:0] UNIT_FMUL    = 3'd3;
    localparam logic [2:0] UNIT_FDIV    = 3'd4;
    localparam logic [2:0] UNIT_ITOF    = 3'd5;
    localparam logic [2:0] UNIT_FTOI    = 3'd6;
    localparam logic [2:0] UNIT_RSVD    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_ABORT = 2'd3
    } mc_state_e;

    localparam int unsigned DEF_IMUL_LAT = 6;
    localparam int unsigned DEF_FADD_LAT = 6;
    localparam int unsigned DEF_FMUL_LAT = 4;
    localparam int unsigned DEF_FDIV_LAT = 6;
    localparam int unsigned DEF_CVT_LAT  = 6;

endpackage

// File: rtl/ex_lat_lookup.sv
// Unit code -> latency table. A latency of 0 marks a single-cycle (or reserved) code.
module ex_lat_lookup
    import ex_pkg::*;
#(
    parameter int unsigned IMUL_LAT = DEF_IMUL_LAT,
    parameter int unsigned FADD_LAT = DEF_FADD_LAT,
    parameter int unsigned FMUL_LAT = DEF_FMUL_LAT,
    parameter int unsigned FDIV_LAT = DEF_FDIV_LAT,
    parameter int unsigned CVT_LAT  = DEF_CVT_LAT
) (
    input  logic [2:0] unit_code,
    output logic [3:0] lat
);

    always_comb begin
        lat = 4'd0;
        case (unit_code)
            UNIT_IMUL:    lat = 4'(IMUL_LAT);
            UNIT_FADDSUB: lat = 4'(FADD_LAT);
            UNIT_FMUL:    lat = 4'(FMUL_LAT);
            UNIT_FDIV:    lat = 4'(FDIV_LAT);
            UNIT_ITOF:    lat = 4'(CVT_LAT);
            UNIT_FTOI:    lat = 4'(CVT_LAT);
            default:      lat = 4'd0;
        endcase
    end

endmodule

// File: rtl/ex_mc_sequencer.sv
// EX-stage multi-cycle sequencer: stalls the pipe for a unit's fixed latency,
// then pulses done; handles FPDiv divide-by-zero abort and flush.
module ex_mc_sequencer
    import ex_pkg::*;
#(
    parameter int unsigned IMUL_LAT = DEF_IMUL_LAT,
    parameter int unsigned FADD_LAT = DEF_FADD_LAT,
    parameter int unsigned FMUL_LAT = DEF_FMUL_LAT,
    parameter int unsigned FDIV_LAT = DEF_FDIV_LAT,
    parameter int unsigned CVT_LAT  = DEF_CVT_LAT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    input  logic [2:0] issue_unit,
    input  logic       flush,
    input  logic       div_by_zero,
    output logic       busy,
    output logic       done,
    output logic [2:0] unit_sel,
    output logic       aclr,
    output logic       exception
);

    mc_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] unit_sel_q, unit_sel_d;
    logic       aclr_q, aclr_d;
    logic       exception_q, exception_d;
    logic [3:0] issue_lat;
    logic       issue_go;

    ex_lat_lookup #(
        .IMUL_LAT (IMUL_LAT),
        .FADD_LAT (FADD_LAT),
        .FMUL_LAT (FMUL_LAT),
        .FDIV_LAT (FDIV_LAT),
        .CVT_LAT  (CVT_LAT)
    ) u_lat (
        .unit_code (issue_unit),
        .lat       (issue_lat)
    );

    assign issue_go = issue_valid && (issue_lat != 4'd0) && !flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            unit_sel_q  <= UNIT_NONE;
            aclr_q      <= 1'b0;
            exception_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            unit_sel_q  <= unit_sel_d;
            aclr_q      <= aclr_d;
            exception_q <= exception_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        unit_sel_d  = unit_sel_q;
        aclr_d      = 1'b0;
        exception_d = 1'b0;
        if (flush) begin
            // Only an op actually occupying a unit needs its pipeline cleared.
            state_d = ST_IDLE;
            aclr_d  = (state_q == ST_RUN);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue_go) begin
                        unit_sel_d = issue_unit;
                        if (issue_unit == UNIT_FDIV && div_by_zero) begin
                            state_d     = ST_ABORT;
                            aclr_d      = 1'b1;
                            exception_d = 1'b1;
                        end else if (issue_lat == 4'd1) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_d   = issue_lat - 4'd1;
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // Abort takes precedence over completion on the last cycle.
                    if (unit_sel_q == UNIT_FDIV && div_by_zero) begin
                        state_d     = ST_ABORT;
                        aclr_d      = 1'b1;
                        exception_d = 1'b1;
                    end else if (cnt_q == 4'd1) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                ST_ABORT: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = rst && (((state_q == ST_IDLE) && issue_go) || (state_q == ST_RUN));
        done      = rst && (state_q == ST_DONE) && !flush;
        unit_sel  = unit_sel_q;
        aclr      = aclr_q;
        exception = exception_q;
    end

endmodule

// File: doc/ex_mc_sequencer.md
Name: ex_mc_sequencer

Overview:
Controller that sequences the multi-cycle functional units of the EX stage: IMul, FPAddSub, FPMul, FPDiv, FPItoF and FPFtoI. It replaces the per-ALU stall counters with a single FSM. On issue of a multi-cycle op it holds the pipeline (busy) for that unit's fixed latency, then pulses done/capture for exactly one cycle. It also handles FPDiv divide-by-zero abort (aclr + exception) and pipeline flush.

Parameters:
IMUL_LAT, 6, total cycles (issue cycle included) before IMul result is valid
FADD_LAT, 6, FPAddSub latency (fadd/fsub)
FMUL_LAT, 4, FPMul latency
FDIV_LAT, 6, FPDiv latency
CVT_LAT, 6, FPItoF/FPFtoI latency
(legal range for every *_LAT: 1..15)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-low (rst==0 resets)
issue_valid  in  1  EX stage holds a valid instruction this cycle
issue_unit  in  3  unit code: 0 single-cycle, 1 IMUL, 2 FADDSUB, 3 FMUL, 4 FDIV, 5 ITOF, 6 FTOI, 7 reserved
flush  in  1  squash the EX instruction (branch/exception from later stage)
div_by_zero  in  1  FPDiv division_by_zero flag
busy  out  1  stall request to hazard unit (BUSY)
done  out  1  one-cycle pulse: selected unit's result is valid, pipeline advances
unit_sel  out  3  code of the in-flight unit; drives the EX result mux
aclr  out  1  registered one-cycle clear to FPDiv/pipelined units
exception  out  1  registered one-cycle divide-by-zero exception

Behaviour:
- Reset (rst==0 at posedge): state IDLE, cnt=0, unit_sel=0, aclr=0, exception=0. busy=0 and done=0 while in reset. Reset mid-operation abandons the op silently; aclr=0.
- States: IDLE, RUN, DONE, ABORT. cnt is a 4-bit down-counter. LAT(code) comes from the parameter table; codes 0 and 7 are single-cycle.
- IDLE:
  - issue_valid & multi-cycle code: latch unit_sel=code.
    - LAT>=2: cnt<=LAT-1, go RUN.
    - LAT==1: go DONE.
  - Single-cycle code or no issue: stay IDLE, busy=0, done=0.
- busy (combinational) = (IDLE & issue_valid & multi-cycle code & !flush) | RUN. The issue cycle counts as the first busy cycle, so there are exactly LAT busy cycles.
- RUN: cnt decrements each cycle; when cnt==1 go DONE. busy=1.
- DONE: busy=0, done=1 for one cycle; unit_sel still valid. Next state is IDLE. issue_valid is ignored in DONE because it is the same held instruction; the next instruction is evaluated in IDLE.
- div_by_zero while in RUN with unit_sel==FDIV, or in the FDIV issue cycle: go ABORT. Next cycle aclr=1 and exception=1 for one cycle, busy=0, done=0. ABORT goes to IDLE. div_by_zero is ignored for other units.
- div_by_zero in the final RUN cycle (cnt==1): ABORT wins; done is never asserted.
- flush: highest priority after reset, from any state.
  - Next state IDLE, and no done/exception for the flushed op.
  - aclr=1 in the next cycle if flushed from RUN.
  - flush in the IDLE issue cycle suppresses issue.
- flush together with div_by_zero: flush wins, exception=0, aclr=1.
- unit_sel holds its value until the next issue; it returns to 0 only on reset.
- aclr and exception are flops: never high in the same cycle as busy=1 from the same op.

Decomposition:
- Shared package ex_pkg:
  - unit code localparams (UNIT_NONE..UNIT_FTOI)
  - FSM state encoding (2 bits)
  - default latency constants, reused by alu_I/alu_F
- Sub-module ex_lat_lookup: combinational code->LAT table, parameterized with the five *_LAT values. Codes 0 and 7 map to 0.
- FSM, counter and output flops live in ex_mc_sequencer.

Test Plan:
- FMUL issue at cycle 0 (issue_valid=1, issue_unit=3, FMUL_LAT=4) -> busy=1 cycles 0-3; done=1 and unit_sel=3 at cycle 4; IDLE at cycle 5, busy=0.
- Back-to-back: FADDSUB (6), then single-cycle op presented after done -> busy 6 cycles, done at cycle 6; single-cycle op at cycle 7 gives busy=0, done=0.
- FDIV issued; div_by_zero=1 at cycle 3 -> busy=0 at cycle 4; aclr=1 and exception=1 at cycle 4 only; done never asserted; IDLE at cycle 5.
- flush=1 at cycle 2 of IMUL (6) -> IDLE at cycle 3 with aclr=1 at cycle 3, busy=0, done/exception=0; flush plus div_by_zero together gives exception=0.
- Parameter LAT=1 (override CVT_LAT=1), ITOF issue -> busy=1 for one cycle only, done at cycle 1.
- rst=0 asserted at cycle 2 of FDIV -> all outputs 0 next cycle; after release, a new issue gets the full latency; issue_unit=7 gives busy=0.
